aes_inv_round: RTL and testbench

AES_INV_ROUND -- requirements
Module: aes_inv_round

---
 rtl/aes_pkg.sv | 87 ++++++++
 rtl/aes_inv_round_inv_sbox.sv | 29 ++
 rtl/aes_inv_round.sv | 109 ++++++++++
 tb/tb_aes_inv_round.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES types, constants and GF(2^8) helpers
// used by the inverse round datapath.
package aes_pkg;

  localparam int BLOCK_W = 128;

  typedef enum logic [1:0] {
    IDLE,
    SUB,
    MIX,
    DONE
  } state_t;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] mul09(input logic [7:0] b);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ b;
  endfunction

  function automatic logic [7:0] mul0b(input logic [7:0] b);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x2 ^ b;
  endfunction

  function automatic logic [7:0] mul0d(input logic [7:0] b);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x4 ^ b;
  endfunction

  function automatic logic [7:0] mul0e(input logic [7:0] b);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x4 ^ x2;
  endfunction

  // Byte b = 4*col + row sits at bits [127-8b -: 8].
  function automatic logic [BLOCK_W-1:0] inv_shift_rows(
    input logic [BLOCK_W-1:0] s
  );
    logic [BLOCK_W-1:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] =
          s[127-8*(4*((c-r+4)%4)+r) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] a);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = a;
    return {
      mul0e(a0) ^ mul0b(a1) ^ mul0d(a2) ^ mul09(a3),
      mul09(a0) ^ mul0e(a1) ^ mul0b(a2) ^ mul0d(a3),
      mul0d(a0) ^ mul09(a1) ^ mul0e(a2) ^ mul0b(a3),
      mul0b(a0) ^ mul0d(a1) ^ mul09(a2) ^ mul0e(a3)
    };
  endfunction

  function automatic logic [BLOCK_W-1:0] inv_mix_columns(
    input logic [BLOCK_W-1:0] s
  );
    logic [BLOCK_W-1:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      o[127-32*c -: 32] = inv_mix_col(s[127-32*c -: 32]);
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_inv_round_inv_sbox.sv
// AES inverse S-box: combinational 256x8 ROM.
// Entry a sits at bits [2047-8a -: 8] of the table.
module inv_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);

  localparam logic [2047:0] TABLE = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  assign y = TABLE[{~a, 3'b111} -: 8];

endmodule

// File: rtl/aes_inv_round.sv
// One AES-128 inverse round, one column of InvSubBytes per cycle,
// with valid/ready handshakes on both sides.
module aes_inv_round
  import aes_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BLOCK_W-1:0] state_in,
  input  logic [BLOCK_W-1:0] round_key,
  input  logic               last_round,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BLOCK_W-1:0] state_out
);

  state_t state, nxt;

  logic [BLOCK_W-1:0] st;
  logic [BLOCK_W-1:0] key;
  logic [BLOCK_W-1:0] res;
  logic               last;
  logic [1:0]         cnt;
  logic [31:0]        col;
  logic [31:0]        sub_col;

  always_comb begin
    col = st[127:96];
    unique case (cnt)
      2'd0: col = st[127:96];
      2'd1: col = st[95:64];
      2'd2: col = st[63:32];
      2'd3: col = st[31:0];
    endcase
  end

  for (genvar i = 0; i < 4; i++) begin : g_sbox
    inv_sbox u_sbox (
      .a(col[31-8*i -: 8]),
      .y(sub_col[31-8*i -: 8])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt       = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) nxt = SUB;
      end
      SUB: begin
        if (cnt == 2'd3) nxt = MIX;
      end
      MIX: begin
        nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st   <= '0;
      key  <= '0;
      last <= 1'b0;
      cnt  <= 2'd0;
      res  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            st   <= inv_shift_rows(state_in);
            key  <= round_key;
            last <= last_round;
            cnt  <= 2'd0;
          end
        end
        SUB: begin
          unique case (cnt)
            2'd0: st[127:96] <= sub_col;
            2'd1: st[95:64]  <= sub_col;
            2'd2: st[63:32]  <= sub_col;
            2'd3: st[31:0]   <= sub_col;
          endcase
          cnt <= cnt + 2'd1;
        end
        MIX: begin
          res <= last ? (st ^ key)
                      : inv_mix_columns(st ^ key);
        end
        DONE: ;
      endcase
    end
  end

  assign state_out = res;

endmodule

// File: tb/tb_aes_inv_round.sv
// Directed-vector bench for aes_inv_round: latency,
// results, back-pressure, mid-round reset and streaming.
module tb_aes_inv_round;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] state_in;
  logic [127:0] round_key;
  logic         last_round;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] state_out;

  int compared;
  int mismatched;

  localparam logic [127:0] S0   = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
  localparam logic [127:0] E28  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] E29  = 128'he6c21c415f0b1dd4653972d51607b7f7;
  localparam logic [127:0] K30  = 128'h1d5b625b403ffbb1d23e5e50c1fe6e44;
  localparam logic [127:0] ONES = {128{1'b1}};

  aes_inv_round dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .state_in(state_in),
    .round_key(round_key),
    .last_round(last_round),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .state_out(state_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one round; inputs are scrambled right after acceptance.
  task automatic send(input logic [127:0] s, input logic [127:0] k,
                      input logic l);
    @(negedge clk);
    state_in   = s;
    round_key  = k;
    last_round = l;
    in_valid   = 1'b1;
    @(posedge clk);
    #1;
    in_valid   = 1'b0;
    state_in   = ~s;
    round_key  = ~k;
    last_round = ~l;
  endtask

  task automatic wait_out(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!out_valid && cyc < 30);
  endtask

  task automatic consume();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    compared++;
    if (out_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_out_valid got=%b want=0", out_valid);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    compared++;
    if (in_ready !== 1'b1 || state_out !== '0) begin
      mismatched++;
      $display("FAIL reset_state got in_ready=%b out=%h want 1/0",
               in_ready, state_out);
    end
  endtask

  task automatic test_last_round(input string name,
                                 input logic [127:0] k,
                                 input logic [127:0] exp);
    int c;
    send(S0, k, 1'b1);
    wait_out(c);
    compared++;
    if (c !== 6) begin
      mismatched++;
      $display("FAIL %s_latency got=%0d want=6", name, c);
    end
    compared++;
    if (state_out !== exp) begin
      mismatched++;
      $display("FAIL %s_result got=%h want=%h", name, state_out, exp);
    end
    consume();
    @(negedge clk);
    compared++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL %s_return got ready=%b valid=%b want 1/0",
               name, in_ready, out_valid);
    end
  endtask

  task automatic test_full_round();
    int c;
    send(S0, K30, 1'b0);
    wait_out(c);
    compared++;
    if (c !== 6) begin
      mismatched++;
      $display("FAIL full_latency got=%0d want=6", c);
    end
    compared++;
    if (state_out !== S0) begin
      mismatched++;
      $display("FAIL full_result got=%h want=%h", state_out, S0);
    end
    consume();
  endtask

  task automatic test_backpressure();
    int c;
    logic ok;
    send(S0, ONES, 1'b1);
    wait_out(c);
    compared++;
    if (state_out !== E29) begin
      mismatched++;
      $display("FAIL bp_result got=%h want=%h", state_out, E29);
    end
    state_in   = 128'h0123456789abcdef0011223344556677;
    round_key  = 128'h0;
    last_round = 1'b1;
    in_valid   = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      compared++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
          state_out !== E29) begin
        mismatched++;
        $display("FAIL bp_hold_%0d got valid=%b ready=%b out=%h want 1/0/%h",
                 i, out_valid, in_ready, state_out, E29);
      end
    end
    in_valid = 1'b0;
    consume();
    ok = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || in_ready !== 1'b1) ok = 1'b0;
    end
    compared++;
    if (ok !== 1'b1) begin
      mismatched++;
      $display("FAIL bp_ignored got stray round want idle");
    end
  endtask

  task automatic test_reset_mid_round();
    logic ok;
    send(S0, 128'h0, 1'b1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    compared++;
    if (out_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL midrst_valid got=%b want=0", out_valid);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    compared++;
    if (in_ready !== 1'b1 || state_out !== '0) begin
      mismatched++;
      $display("FAIL midrst_idle got ready=%b out=%h want 1/0",
               in_ready, state_out);
    end
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) ok = 1'b0;
    end
    compared++;
    if (ok !== 1'b1) begin
      mismatched++;
      $display("FAIL midrst_no_pulse got out_valid pulse want none");
    end
    test_last_round("after_rst", 128'h0, E28);
  endtask

  task automatic test_back_to_back();
    logic [127:0] vs [3];
    logic [127:0] vk [3];
    logic         vl [3];
    logic [127:0] ve [3];
    int acc [3];
    int idx;
    int oidx;
    int cyc;
    vs = '{S0, S0, S0};
    vk = '{128'h0, ONES, K30};
    vl = '{1'b1, 1'b1, 1'b0};
    ve = '{E28, E29, S0};
    idx  = 0;
    oidx = 0;
    cyc  = 0;
    out_ready = 1'b1;
    while (oidx < 3 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (out_valid === 1'b1) begin
        compared++;
        if (state_out !== ve[oidx]) begin
          mismatched++;
          $display("FAIL b2b_result_%0d got=%h want=%h",
                   oidx, state_out, ve[oidx]);
        end
        oidx++;
      end
      if (in_ready === 1'b1) begin
        if (idx < 3) begin
          state_in   = vs[idx];
          round_key  = vk[idx];
          last_round = vl[idx];
          in_valid   = 1'b1;
          acc[idx]   = cyc;
          idx++;
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    compared++;
    if (oidx !== 3) begin
      mismatched++;
      $display("FAIL b2b_count got=%0d want=3", oidx);
    end
    for (int i = 1; i < 3; i++) begin
      compared++;
      if (acc[i] - acc[i-1] !== 7) begin
        mismatched++;
        $display("FAIL b2b_gap_%0d got=%0d want=7",
                 i, acc[i] - acc[i-1]);
      end
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rst        = 1'b0;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    state_in   = '0;
    round_key  = '0;
    last_round = 1'b0;
    test_reset();
    test_last_round("zero_key", 128'h0, E28);
    test_last_round("ones_key", ONES, E29);
    test_full_round();
    test_backpressure();
    test_reset_mid_round();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
